result_bram_drain: RTL and testbench
====================================

Name: result_bram_drain

Overview:
- Read-side counterpart to the matrix-multiply output BRAM writer.
- After a product is complete, it walks the output BRAM one block-word per address. Each word holds one BLOCK_SIZE x BLOCK_SIZE result block of CHUNK_SIZE elements.
- It streams the words out on a valid/ready interface with a last marker.
- It absorbs BRAM read latency and downstream backpressure through a small credit-controlled FIFO.

Parameters:
- WIDTH, 16, element width in bits (Q-format, FRAC_WIDTH is irrelevant here; data is passed through untouched)
- CHUNK_SIZE, 4, elements per BRAM word; must equal BLOCK_SIZE*BLOCK_SIZE
- BLOCK_SIZE, 2, systolic block dimension
- ROW_SIZE_MAT_C, 4, result rows in blocks
- COL_SIZE_MAT_C, 3, result columns in blocks
- ADDR_WIDTH, 12, BRAM address width
- BRAM_LATENCY, 2, cycles from bram_en/bram_addr to valid bram_dout (1..4)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to drain the whole result; honoured only when idle
- bram_en  out  1  read enable to output BRAM port B
- bram_addr  out  ADDR_WIDTH  read address
- bram_dout  in  WIDTH*CHUNK_SIZE  read data, valid BRAM_LATENCY cycles after a bram_en cycle
- m_data  out  WIDTH*CHUNK_SIZE  streamed block word
- m_valid  out  1  m_data valid
- m_ready  in  1  downstream accept
- m_last  out  1  high with the final block word
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the final handshake

Behaviour:
- Derived constants:
  - MAX_FLAG = ROW_SIZE_MAT_C*COL_SIZE_MAT_C (12 at defaults).
  - FIFO_DEPTH = BRAM_LATENCY+2.
- Reset (rst=1 at an edge): all outputs 0, FSM to IDLE, counters, FIFO and in-flight shift register cleared. Applies mid-operation as well; read data still in flight from before reset is discarded and never appears on m_data.
- FSM:
  - IDLE: start=1 moves to ISSUE; busy=1 from the next cycle.
  - ISSUE: issue reads while allowed; after address MAX_FLAG-1 is issued, go to FLUSH.
  - FLUSH: stay until the in-flight register and FIFO are empty and the last beat has handshaken, then go to DONE.
  - DONE: done=1 and busy=0 for one cycle, then IDLE. A start in the DONE cycle is ignored.
- Issue rule (ISSUE state only):
  - Read issued when inflight+fifo_count < FIFO_DEPTH, counting a same-cycle pop as freeing a slot.
  - Issuing drives bram_en=1 and bram_addr = current index, then increments the index.
  - bram_en is 0 whenever no read is issued.
- Order: row-major by block, index k = r*COL_SIZE_MAT_C + c, addresses 0..MAX_FLAG-1. bram_addr is zero-extended.
- In-flight tracking: a BRAM_LATENCY-deep valid shift register. When its tail is 1, bram_dout is pushed into the FIFO. The credit rule guarantees the FIFO never overflows; an overflow is an assertion failure.
- Output stage:
  - m_valid = FIFO not empty; m_data = FIFO head (registered FIFO, no combinational path from m_ready to m_data).
  - Pop when m_valid && m_ready.
  - m_data and m_last hold stable while m_valid && !m_ready.
- m_last is 1 only on the beat carrying index MAX_FLAG-1, tracked by a beat counter.
- Latency: start at edge t gives the first bram_en in cycle t+1 and the first m_valid in cycle t+2+BRAM_LATENCY.
- Throughput: one beat per cycle when m_ready=1.
- Start while busy is ignored. The start input is not latched.

Optional Feature:
- Macro DRAIN_COL_MAJOR_EN.
- Defined: block traversal is column-major, k = r*COL_SIZE_MAT_C + c with r incrementing fastest (defaults: 0,3,6,9,1,4,7,10,2,5,8,11).
  - Uses separate r/c counters with wrap: r wraps at ROW_SIZE_MAT_C-1, then c increments.
  - m_last still marks the MAX_FLAG-th beat.
- Undefined: row-major sequential addresses, single counter.

Decomposition:
- Shared package `matmul_pkg`:
  - MAX_FLAG and FIFO_DEPTH derivation functions.
  - FSM state enum (IDLE, ISSUE, FLUSH, DONE).
  - A clog2 helper for counter widths.
- One sub-module: `sync_fifo_fwft`, the registered first-word-fall-through FIFO with parameterised width/depth and count output. It is reusable for the input-side loader.

Test Plan:
- Reset: rst held 3 cycles with m_ready=1 -> bram_en, m_valid, m_last, busy and done are all 0; no activity until start.
- Full drain: BRAM word k = {4{16'(k)}}, m_ready=1, start at t -> 12 beats with data k=0..11 on consecutive cycles from t+4; m_last only on k=11; done pulses one cycle after the last beat; busy=0 with it.
- Backpressure: m_ready=0 for cycles t+5..t+14 -> at most 4 outstanding reads; m_data stable while stalled; all 12 words delivered exactly once and in order.
- Start while busy: extra start pulses at t+3 and on the done cycle -> ignored, exactly 12 beats, one done.
- Reset mid-run: rst asserted after beat 5 with reads in flight -> everything cleared, no stale beat; a following start delivers words 0..11 from scratch.
- Col-major build (DRAIN_COL_MAJOR_EN): same stimulus as the full drain -> addresses and data in order 0,3,6,9,1,4,7,10,2,5,8,11; m_last on word 11.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply result path: drain FSM states
// and the derived-constant helpers used to size counters and the output FIFO.
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    FLUSH,
    DONE
  } state_t;

  // Bits needed to hold values 0..value-1, never less than one bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

  function automatic int max_flag(input int rows, input int cols);
    return rows * cols;
  endfunction

  function automatic int fifo_depth(input int bram_latency);
    return bram_latency + 2;
  endfunction

endpackage

// File: rtl/result_bram_drain_if.sv
// BRAM read port plus the outgoing valid/ready/last block-word stream.
// The master side is the drain engine; the slave side is BRAM plus consumer.
interface result_bram_drain_if #(
  parameter int WIDTH      = 16,
  parameter int CHUNK_SIZE = 4,
  parameter int ADDR_WIDTH = 12
);
  logic                          bram_en;
  logic [ADDR_WIDTH-1:0]         bram_addr;
  logic [WIDTH*CHUNK_SIZE-1:0]   bram_dout;
  logic [WIDTH*CHUNK_SIZE-1:0]   m_data;
  logic                          m_valid;
  logic                          m_ready;
  logic                          m_last;

  modport master (
    output bram_en, bram_addr, m_data, m_valid, m_last,
    input  bram_dout, m_ready
  );

  modport slave (
    input  bram_en, bram_addr, m_data, m_valid, m_last,
    output bram_dout, m_ready
  );
endinterface

// File: rtl/sync_fifo_fwft.sv
// Registered first-word-fall-through FIFO with occupancy count. The head word
// comes straight from storage, so pop has no combinational path to pop_data.
module sync_fifo_fwft
  import matmul_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int CW   = clog2(DEPTH + 1),
  localparam int PW   = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && ((count != CW'(DEPTH)) || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; clearing the pointers and count
  // empties the FIFO, and resetting a memory array blocks RAM inference.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && !do_push))
    else $error("sync_fifo_fwft: push into full FIFO");

endmodule

// File: rtl/result_bram_drain.sv
// Drains the result BRAM one block word per address onto a valid/ready stream,
// using credit-based read issue so the output FIFO never overflows.
// Build option DRAIN_COL_MAJOR_EN selects column-major block traversal.
module result_bram_drain
  import matmul_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int CHUNK_SIZE     = 4,
  parameter int BLOCK_SIZE     = 2,
  parameter int ROW_SIZE_MAT_C = 4,
  parameter int COL_SIZE_MAT_C = 3,
  parameter int ADDR_WIDTH     = 12,
  parameter int BRAM_LATENCY   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  result_bram_drain_if.master     bus,
  output logic                    busy,
  output logic                    done
);

  localparam int MAX_FLAG   = max_flag(ROW_SIZE_MAT_C, COL_SIZE_MAT_C);
  localparam int FIFO_DEPTH = fifo_depth(BRAM_LATENCY);
  localparam int DW         = WIDTH * CHUNK_SIZE;
  localparam int IW         = clog2(MAX_FLAG);
  localparam int CW         = clog2(FIFO_DEPTH + 1);

  if (CHUNK_SIZE != BLOCK_SIZE * BLOCK_SIZE) begin : g_bad_chunk
    $error("result_bram_drain: CHUNK_SIZE must equal BLOCK_SIZE*BLOCK_SIZE");
  end
  if (BRAM_LATENCY < 1 || BRAM_LATENCY > 4) begin : g_bad_latency
    $error("result_bram_drain: BRAM_LATENCY must be 1..4");
  end

  state_t                  state;
  state_t                  state_nxt;
  logic                    issue;
  logic                    pop;
  logic                    credit_ok;
  logic                    fifo_empty;
  logic [CW-1:0]           fifo_count;
  logic [DW-1:0]           fifo_head;
  logic [BRAM_LATENCY-1:0] inflight;
  logic [IW-1:0]           issue_cnt;
  logic [IW-1:0]           beat_cnt;
  logic [IW-1:0]           addr_k;

  assign pop = !fifo_empty && bus.m_ready;

  // A slot freed by this cycle's pop may be reused by this cycle's read.
  assign credit_ok = ($countones(inflight) + int'(fifo_count)) < (FIFO_DEPTH + int'(pop));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case statement can leave a value held and infer a latch.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = ISSUE;
      ISSUE: begin
        issue = credit_ok;
        if (issue && issue_cnt == IW'(MAX_FLAG - 1)) state_nxt = FLUSH;
      end
      FLUSH: if (pop && bus.m_last) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight  <= '0;
      issue_cnt <= '0;
      beat_cnt  <= '0;
    end else begin
      inflight <= (inflight << 1) | BRAM_LATENCY'(issue);
      if (state == IDLE && start) begin
        issue_cnt <= '0;
        beat_cnt  <= '0;
      end else begin
        if (issue) issue_cnt <= issue_cnt + 1'b1;
        if (pop)   beat_cnt  <= beat_cnt + 1'b1;
      end
    end
  end

`ifdef DRAIN_COL_MAJOR_EN
  localparam int RW  = clog2(ROW_SIZE_MAT_C);
  localparam int CLW = clog2(COL_SIZE_MAT_C + 1);

  logic [RW-1:0]  r_cnt;
  logic [CLW-1:0] c_cnt;

  // Row index moves fastest; the column steps when the row wraps.
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && start)) begin
      r_cnt <= '0;
      c_cnt <= '0;
    end else if (issue) begin
      if (r_cnt == RW'(ROW_SIZE_MAT_C - 1)) begin
        r_cnt <= '0;
        c_cnt <= c_cnt + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign addr_k = IW'(int'(r_cnt) * COL_SIZE_MAT_C + int'(c_cnt));
`else
  assign addr_k = issue_cnt;
`endif

  sync_fifo_fwft #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight[BRAM_LATENCY-1]),
    .push_data (bus.bram_dout),
    .pop       (pop),
    .pop_data  (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.bram_en   = issue;
  assign bus.bram_addr = issue ? ADDR_WIDTH'(addr_k) : '0;
  assign bus.m_valid   = !fifo_empty;
  assign bus.m_data    = fifo_head;
  assign bus.m_last    = !fifo_empty && (beat_cnt == IW'(MAX_FLAG - 1));
  assign busy          = (state == ISSUE) || (state == FLUSH);
  assign done          = (state == DONE);

endmodule

// File: tb/tb_result_bram_drain.sv
// Directed + randomized bench for result_bram_drain: a latency-accurate BRAM
// model, a traversal-order model and a negedge monitor feeding a scoreboard.
module tb_result_bram_drain;
  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int BLOCK = 2;
  localparam int ROWS  = 4;
  localparam int COLS  = 3;
  localparam int AW    = 12;
  localparam int LAT   = 2;
  localparam int MF    = ROWS * COLS;
  localparam int DEPTH = LAT + 2;
  localparam int DW    = WIDTH * CHUNK;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy;
  logic done;

  result_bram_drain_if #(.WIDTH(WIDTH), .CHUNK_SIZE(CHUNK), .ADDR_WIDTH(AW)) bus ();

  result_bram_drain #(
    .WIDTH(WIDTH), .CHUNK_SIZE(CHUNK), .BLOCK_SIZE(BLOCK),
    .ROW_SIZE_MAT_C(ROWS), .COL_SIZE_MAT_C(COLS),
    .ADDR_WIDTH(AW), .BRAM_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // BRAM model: LAT-stage read pipeline; garbage when no read was issued.
  logic [DW-1:0] mem  [MF];
  logic [DW-1:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= (bus.bram_en && bus.bram_addr < MF) ? mem[bus.bram_addr] : {$urandom, $urandom};
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.bram_dout = pipe[LAT-1];

  int            n_cmp = 0;
  int            n_err = 0;
  int            t_start;
  logic [DW-1:0] beat_data_q [$];
  bit            beat_last_q [$];
  int            beat_cyc_q  [$];
  int            addr_q      [$];
  int            addr_cyc_q  [$];
  int            done_cyc_q  [$];
  int            order       [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: samples at negedge, records handshakes/reads, checks invariants.
  initial begin
    int            iss_total;
    int            acc_total;
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    iss_total  = 0;
    acc_total  = 0;
    prev_stall = 0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        iss_total  = 0;
        acc_total  = 0;
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", bus.m_valid, 1);
          check("stall_data", bus.m_data, prev_data);
          check("stall_last", bus.m_last, prev_last);
        end
        if (bus.m_valid && bus.m_ready) begin
          beat_data_q.push_back(bus.m_data);
          beat_last_q.push_back(bus.m_last);
          beat_cyc_q.push_back(edge_n);
          acc_total++;
        end
        if (bus.bram_en) begin
          addr_q.push_back(int'(bus.bram_addr));
          addr_cyc_q.push_back(edge_n);
          iss_total++;
          check("outstanding_le_depth", (iss_total - acc_total) <= DEPTH, 1);
          check("busy_while_issuing", busy, 1);
        end
        if (done) begin
          done_cyc_q.push_back(edge_n);
          check("busy_low_at_done", busy, 0);
        end
        prev_stall = bus.m_valid && !bus.m_ready;
        prev_data  = bus.m_data;
        prev_last  = bus.m_last;
      end
    end
  end

  // Traversal order from the block-index definition k = r*COLS + c.
  task automatic build_order();
    order.delete();
`ifdef DRAIN_COL_MAJOR_EN
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++) order.push_back(r * COLS + c);
`else
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) order.push_back(r * COLS + c);
`endif
  endtask

  task automatic fill_pattern();
    for (int k = 0; k < MF; k++) mem[k] = {CHUNK{16'(k)}};
  endtask

  task automatic fill_random();
    for (int k = 0; k < MF; k++) mem[k] = {$urandom, $urandom};
  endtask

  task automatic clear_q();
    beat_data_q.delete(); beat_last_q.delete(); beat_cyc_q.delete();
    addr_q.delete(); addr_cyc_q.delete(); done_cyc_q.delete();
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start   = 1'b1;
    t_start = edge_n + 1;
  endtask

  // ready_mode: 0 always ready, 1 stall window t+5..t+14, 2 random.
  task automatic run_until_done(input int ready_mode, input bit extra_starts, input int settle);
    bit seen;
    int n;
    seen = 0;
    n    = 0;
    while (!seen && n < 400) begin
      @(posedge clk); #1;
      n++;
      case (ready_mode)
        1:       bus.m_ready = !(edge_n >= t_start + 4 && edge_n < t_start + 14);
        2:       bus.m_ready = ($urandom_range(0, 3) != 0);
        default: bus.m_ready = 1'b1;
      endcase
      seen  = done;
      start = extra_starts && (edge_n == t_start + 2 || done);
    end
    check("done_within_budget", seen, 1);
    @(posedge clk); #1;
    start       = 1'b0;
    bus.m_ready = 1'b1;
    repeat (settle) @(posedge clk);
    #1;
  endtask

  task automatic verify_run(input string name, input bit timed);
    check({name, "_beat_count"}, beat_data_q.size(), MF);
    check({name, "_addr_count"}, addr_q.size(), MF);
    check({name, "_done_count"}, done_cyc_q.size(), 1);
    for (int i = 0; i < MF && i < beat_data_q.size(); i++) begin
      check($sformatf("%s_beat%0d_data", name, i), beat_data_q[i], mem[order[i]]);
      check($sformatf("%s_beat%0d_last", name, i), beat_last_q[i], (i == MF - 1));
      if (timed) check($sformatf("%s_beat%0d_cycle", name, i), beat_cyc_q[i], t_start + 1 + LAT + i);
    end
    for (int i = 0; i < MF && i < addr_q.size(); i++) begin
      check($sformatf("%s_addr%0d", name, i), addr_q[i], order[i]);
      if (timed) check($sformatf("%s_addr%0d_cycle", name, i), addr_cyc_q[i], t_start + i);
    end
    if (done_cyc_q.size() > 0 && beat_cyc_q.size() > 0)
      check({name, "_done_after_last"}, done_cyc_q[0], beat_cyc_q[beat_cyc_q.size()-1] + 1);
  endtask

  task automatic check_quiet(input string name);
    check({name, "_bram_en"}, bus.bram_en, 0);
    check({name, "_m_valid"}, bus.m_valid, 0);
    check({name, "_m_last"}, bus.m_last, 0);
    check({name, "_m_data"}, bus.m_data, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
  endtask

  initial begin
    int n;
    build_order();
    bus.m_ready = 1'b1;
    fill_pattern();

    // Reset held three cycles, then idle with no start.
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("idle_no_reads", addr_q.size(), 0);
    check("idle_no_beats", beat_data_q.size(), 0);
    check("idle_busy", busy, 0);

    // Full drain, word k = {4{k}}, always ready: exact latency and throughput.
    clear_q();
    pulse_start();
    run_until_done(0, 0, 5);
    verify_run("full", 1);

    // Backpressure window with random contents.
    clear_q();
    fill_random();
    pulse_start();
    run_until_done(1, 0, 5);
    verify_run("bp", 0);

    // Extra starts while busy and in the done cycle are ignored.
    clear_q();
    fill_random();
    pulse_start();
    run_until_done(0, 1, 20);
    verify_run("busy_start", 1);
    check("busy_start_idle_after", busy, 0);

    // Reset after beat 5 with reads in flight.
    clear_q();
    pulse_start();
    n = 0;
    while (beat_data_q.size() < 6 && n < 100) begin
      @(posedge clk); #1;
      n++;
      start = 1'b0;
    end
    check("mid_reset_reached_beat5", beat_data_q.size() >= 6, 1);
    rst         = 1'b1;
    bus.m_ready = 1'b0;
    @(posedge clk); #1;
    check_quiet("mid_reset");
    @(posedge clk); #1;
    rst         = 1'b0;
    bus.m_ready = 1'b1;
    clear_q();
    repeat (10) @(posedge clk);
    #1;
    check("post_reset_no_stale_beat", beat_data_q.size(), 0);
    check("post_reset_no_reads", addr_q.size(), 0);

    // Fresh run after reset with random contents and random backpressure.
    clear_q();
    fill_random();
    pulse_start();
    run_until_done(2, 0, 5);
    verify_run("after_reset", 0);

    // Two more randomized runs.
    for (int r = 0; r < 2; r++) begin
      clear_q();
      fill_random();
      pulse_start();
      run_until_done(2, 0, 5);
      verify_run($sformatf("rand%0d", r), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
